// File: rtl/half_adder.sv
// half_adder: per-lane a^b/a&b on sum/carry plus registered sum_q/carry_q/out_valid (clk, rst_n, in_valid); define HA_STATS_EN to add cnt_clr and a saturating carry_cnt
module half_adder #(
  parameter int WIDTH = 1
`ifdef HA_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
`ifdef HA_STATS_EN
  , input  logic             cnt_clr,
  output logic [CNT_W-1:0] carry_cnt
`endif
);
  assign sum   = a ^ b;
  assign carry = a & b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
`ifdef HA_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) carry_cnt <= '0;
    else if (cnt_clr) carry_cnt <= '0;
    else if (in_valid && |carry && !(&carry_cnt)) carry_cnt <= carry_cnt + CNT_W'(1);
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of half_adder comb, registered, reset and (with HA_STATS_EN) counter paths
module tb_half_adder;
  logic clk, clk_en, rst_n, in_valid;
  logic a1, b1, sum1, carry1, sum_q1, carry_q1, out_valid1;
  logic [3:0] a4, b4, sum4, carry4, sum_q4, carry_q4;
  logic out_valid4;
  int checks = 0;
  int failures = 0;
`ifdef HA_STATS_EN
  logic cnt_clr;
  logic [1:0] carry_cnt1;
  logic [15:0] carry_cnt4;
`endif
  half_adder #(
    .WIDTH(1)
`ifdef HA_STATS_EN
    , .CNT_W(2)
`endif
  ) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
    .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1), .out_valid(out_valid1)
`ifdef HA_STATS_EN
    , .cnt_clr(cnt_clr), .carry_cnt(carry_cnt1)
`endif
  );
  half_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid),
    .sum(sum4), .carry(carry4), .sum_q(sum_q4), .carry_q(carry_q4), .out_valid(out_valid4)
`ifdef HA_STATS_EN
    , .cnt_clr(cnt_clr), .carry_cnt(carry_cnt4)
`endif
  );
  always #5 clk = clk_en ? ~clk : clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic a, input logic b);
    @(negedge clk);
    in_valid = v;
    a1 = a;
    b1 = b;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] vec [4];
    logic [1:0] exp [4];
    vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    exp = '{2'b00, 2'b10, 2'b10, 2'b01};
    clk = 0; clk_en = 0; rst_n = 1; in_valid = 0;
    a1 = 0; b1 = 0; a4 = 0; b4 = 0;
`ifdef HA_STATS_EN
    cnt_clr = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = vec[i];
      #10;
      check($sformatf("tt%0d_sum", i), 32'(sum1), 32'(exp[i][1]));
      check($sformatf("tt%0d_carry", i), 32'(carry1), 32'(exp[i][0]));
    end
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check("w4_sum", 32'(sum4), 'b0110);
    check("w4_carry", 32'(carry4), 'b1000);
    rst_n = 0;
    #1;
    check("rst_sum_q", 32'(sum_q1), 0);
    check("rst_carry_q", 32'(carry_q1), 0);
    check("rst_out_valid", 32'(out_valid1), 0);
    rst_n = 1;
    clk_en = 1;
    drive(1, 1, 1);
    tick;
    check("rel_sum_q", 32'(sum_q1), 0);
    check("rel_carry_q", 32'(carry_q1), 1);
    check("rel_out_valid", 32'(out_valid1), 1);
    check("w4_sum_q", 32'(sum_q4), 'b0110);
    check("w4_carry_q", 32'(carry_q4), 'b1000);
    drive(1, 1, 0);
    tick;
    check("cap_sum_q", 32'(sum_q1), 1);
    check("cap_carry_q", 32'(carry_q1), 0);
    drive(0, 1, 1);
    a4 = 4'b1111; b4 = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("hold%0d_sum_q", i), 32'(sum_q1), 1);
      check($sformatf("hold%0d_carry_q", i), 32'(carry_q1), 0);
      check($sformatf("hold%0d_out_valid", i), 32'(out_valid1), 0);
      check($sformatf("hold%0d_carry", i), 32'(carry1), 1);
      check($sformatf("hold%0d_w4_sum_q", i), 32'(sum_q4), 'b0110);
    end
    check("w4b_sum", 32'(sum4), 'b1010);
    check("w4b_carry", 32'(carry4), 'b0101);
    drive(1, 0, 1);
    tick;
    check("w4b_sum_q", 32'(sum_q4), 'b1010);
    check("w4b_carry_q", 32'(carry_q4), 'b0101);
    #2 rst_n = 0;
    #1;
    check("mid_rst_sum_q", 32'(sum_q1), 0);
    check("mid_rst_out_valid", 32'(out_valid1), 0);
    check("mid_rst_w4_carry_q", 32'(carry_q4), 0);
    @(negedge clk);
    rst_n = 1;
    tick;
    check("post_rst_sum_q", 32'(sum_q1), 1);
    check("post_rst_out_valid", 32'(out_valid1), 1);
`ifdef HA_STATS_EN
    @(negedge clk) cnt_clr = 1;
    tick;
    check("cnt_clr0", 32'(carry_cnt1), 0);
    @(negedge clk) cnt_clr = 0;
    drive(1, 1, 0);
    tick;
    check("cnt_nocarry", 32'(carry_cnt1), 0);
    drive(0, 1, 1);
    tick;
    check("cnt_invalid", 32'(carry_cnt1), 0);
    drive(1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("cnt%0d", i), 32'(carry_cnt1), (i < 3) ? i + 1 : 3);
    end
    @(negedge clk) cnt_clr = 1;
    tick;
    check("cnt_clr_prio", 32'(carry_cnt1), 0);
    @(negedge clk) cnt_clr = 0;
    tick;
    check("cnt_restart", 32'(carry_cnt1), 1);
    #2 rst_n = 0;
    #1;
    check("cnt_rst", 32'(carry_cnt1), 0);
    rst_n = 1;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
